// File: rtl/msg_block_buffer_if.sv
// msg_block_buffer_if
//   Bundles the two handshakes around the BLAKE2s message block buffer:
//   the byte stream arriving from the I/O interface's block-data stage and
//   the 64-byte block handed to the compression core.
//   Ports (as seen by the buffer, modport slave):
//     data_v_i, data_i, data_idx_i      - message byte, valid, lane 0..63
//     block_first_i, block_last_i       - block position within the message
//     kk_i, ll_i                        - key length and message length
//     ready_o                           - buffer accepts bytes
//     block_v_o, block_ready_i          - block handshake to compression
//     m_o, t_o, first_o, last_o         - presented block and its metadata
//     overrun_o                         - sticky: byte arrived while not ready
//   modport master is the opposite view, used by whoever drives the buffer.
interface msg_block_buffer_if #(
   parameter int TW = 64
);
   logic          data_v_i;
   logic [7:0]    data_i;
   logic [5:0]    data_idx_i;
   logic          block_first_i;
   logic          block_last_i;
   logic [5:0]    kk_i;
   logic [TW-1:0] ll_i;
   logic          ready_o;
   logic          block_v_o;
   logic          block_ready_i;
   logic [511:0]  m_o;
   logic [TW-1:0] t_o;
   logic          first_o;
   logic          last_o;
   logic          overrun_o;

   modport slave (
      input  data_v_i, data_i, data_idx_i, block_first_i, block_last_i,
      input  kk_i, ll_i, block_ready_i,
      output ready_o, block_v_o, m_o, t_o, first_o, last_o, overrun_o
   );

   modport master (
      output data_v_i, data_i, data_idx_i, block_first_i, block_last_i,
      output kk_i, ll_i, block_ready_i,
      input  ready_o, block_v_o, m_o, t_o, first_o, last_o, overrun_o
   );
endinterface

// File: rtl/msg_block_buffer.sv
// msg_block_buffer
//   Assembles the byte stream from the I/O interface into 64-byte BLAKE2s
//   message blocks, keeps the running byte counter t and presents each
//   completed block to the compression core with a valid/ready handshake.
//   Ports:
//     clk     - clock
//     nreset  - synchronous active-low reset
//     bus     - msg_block_buffer_if.slave (byte input, block output, status)
//   Two states: FILL accepts bytes (ready_o=1); HOLD presents a finished
//   block (block_v_o=1) until the core takes it.  All outputs are registers.
module msg_block_buffer #(
   parameter int TW = 64
) (
   input  logic                  clk,
   input  logic                  nreset,
   msg_block_buffer_if.slave     bus
);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [TW-1:0] T_ONE     = TW'(1);
   localparam logic [TW-1:0] T_ZERO    = TW'(0);
   // the key block always counts as a full 64 bytes of t
   localparam logic [TW-1:0] KEY_BYTES = TW'(64);

   state_t         state_r;
   state_t         state_next_s;
   logic           ready_r;
   logic           block_v_r;
   logic [511:0]   m_r;
   logic [511:0]   m_next_s;
   logic [TW-1:0]  t_r;
   logic [TW-1:0]  t_o_r;
   logic           first_r;
   logic           last_r;
   logic           overrun_r;

   logic           accept_s;
   logic           overrun_s;
   logic [TW-1:0]  t_new_s;
   logic [TW-1:0]  total_s;
   logic           at_total_s;
   logic           complete_s;

   // byte acceptance, counter update and block completion decode
   always_comb begin
      accept_s   = 1'b0;
      overrun_s  = 1'b0;
      t_new_s    = t_r;
      total_s    = bus.ll_i;
      at_total_s = 1'b0;
      complete_s = 1'b0;

      accept_s  = bus.data_v_i & (state_r == ST_FILL);
      // a byte offered while a block is held is lost, including the handoff cycle
      overrun_s = bus.data_v_i & (state_r == ST_HOLD);

      if ((bus.data_idx_i == 6'd0) && bus.block_first_i) begin
         t_new_s = T_ONE;
      end else begin
         t_new_s = t_r + T_ONE;
      end

      if (bus.kk_i != 6'd0) begin
         total_s = bus.ll_i + KEY_BYTES;
      end else begin
         total_s = bus.ll_i + T_ZERO;
      end

      at_total_s = bus.block_last_i & (t_new_s == total_s);
      complete_s = accept_s & ((bus.data_idx_i == 6'd63) | at_total_s);
   end

   // next-state logic for the fill/hold handshake
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_FILL: begin
            if (complete_s) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_FILL;
            end
         end
         ST_HOLD: begin
            if (bus.block_ready_i) begin
               state_next_s = ST_FILL;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_FILL;
         end
      endcase
   end

   // next buffer contents: lane 0 restarts the block with all other lanes zeroed
   always_comb begin
      m_next_s = m_r;
      if (accept_s) begin
         if (bus.data_idx_i == 6'd0) begin
            m_next_s       = 512'd0;
            m_next_s[7:0]  = bus.data_i;
         end else begin
            m_next_s[{bus.data_idx_i, 3'b000} +: 8] = bus.data_i;
         end
      end else begin
         m_next_s = m_r;
      end
   end

   // state, buffer, counter and output registers
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_r   <= ST_FILL;
         ready_r   <= 1'b1;
         block_v_r <= 1'b0;
         m_r       <= 512'd0;
         t_r       <= T_ZERO;
         t_o_r     <= T_ZERO;
         first_r   <= 1'b0;
         last_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         ready_r   <= (state_next_s == ST_FILL);
         block_v_r <= (state_next_s == ST_HOLD);
         m_r       <= m_next_s;
         if (accept_s) begin
            t_r <= t_new_s;
         end
         if (complete_s) begin
            t_o_r   <= t_new_s;
            first_r <= bus.block_first_i;
            last_r  <= at_total_s;
         end
         if (overrun_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign bus.ready_o   = ready_r;
   assign bus.block_v_o = block_v_r;
   assign bus.m_o       = m_r;
   assign bus.t_o       = t_o_r;
   assign bus.first_o   = first_r;
   assign bus.last_o    = last_r;
   assign bus.overrun_o = overrun_r;

endmodule
